alarm_trigger: RTL and testbench
================================

# alarm_trigger

Initiator side of the alert handshake: holds the stored alarm time, compares it against the running time-of-day, and drives `enable` into the downstream `alert_counter`. It waits for that block's `alert_off` completion flag, then releases `enable` and waits for the flag to clear before re-arming. It sits between the time-keeping counters and `alert_counter`, and adds dismiss, snooze with wrap-around time arithmetic, and a snooze limit.

## Interface
- `SNOOZE_MIN`, 5, minutes added to the current target per snooze (1–59)
- `MAX_SNOOZE`, 3, snoozes allowed per alarm event (1–7)

Ports:
- `clk`  input  1  system clock; all state changes on rising edge
- `rst_n`  input  1  reset, asynchronous, active-low
- `tick`  input  1  one-cycle 1 Hz strobe; time inputs are valid on this cycle
- `cur_hour`  input  5  current hour, 0–23
- `cur_min`  input  6  current minute, 0–59
- `cur_sec`  input  6  current second, 0–59
- `alarm_on`  input  1  arm switch (level)
- `alarm_set`  input  1  one-cycle pulse that loads `set_hour`/`set_min`
- `set_hour`  input  5  new alarm hour
- `set_min`  input  6  new alarm minute
- `snooze`  input  1  one-cycle button pulse
- `stop`  input  1  one-cycle dismiss pulse
- `alert_off`  input  1  completion flag from `alert_counter`
- `enable`  output  1  request to `alert_counter`; registered
- `armed`  output  1  high in state ARMED
- `ringing`  output  1  high in state RINGING
- `snoozing`  output  1  high in state SNOOZE
- `snooze_cnt`  output  3  snoozes taken in the current event

## Operation
- Registers:
  - stored alarm `al_h`/`al_m`
  - active target `tg_h`/`tg_m`
  - `snooze_cnt`
  - state
- States and transitions:
  - IDLE: `alarm_on`=1 → ARMED. On entry, `tg` ← `al`.
  - ARMED: `tick`=1 and `cur_hour`==`tg_h` and `cur_min`==`tg_m` and `cur_sec`==0 → RINGING.
  - RINGING: `enable`=1.
    - `alert_off`=1 → RELEASE.
    - `snooze`=1 and `snooze_cnt`<`MAX_SNOOZE` → SNOOZE.
    - `stop`=1 → RELEASE.
  - SNOOZE: `enable`=0.
    - Match against `tg` (same rule as ARMED) → RINGING.
    - `stop`=1 → RELEASE.
  - RELEASE: `enable`=0. When `alert_off` is sampled 0, go to ARMED if `alarm_on`=1, else IDLE. On exit, `snooze_cnt` ← 0 and `tg` ← `al`.
- Snooze arithmetic, on the SNOOZE transition:
  - `m` = `tg_m` + `SNOOZE_MIN`.
  - If `m` ≥ 60: `tg_m` ← `m`−60 and `tg_h` ← (`tg_h`+1) mod 24.
  - Otherwise `tg_m` ← `m`.
  - `snooze_cnt` increments.
- `snooze` in RINGING when `snooze_cnt`==`MAX_SNOOZE`: ignored, ringing continues.
- `alarm_set`:
  - In IDLE or ARMED: loads `al` and `tg` at the same edge.
  - In RINGING, SNOOZE or RELEASE: ignored.
- Priority within one cycle, highest first:
  1. `alarm_on`=0
  2. `stop`
  3. `snooze`
  4. `alert_off`
  5. time match
- `alarm_on`=0 from ARMED → IDLE. From RINGING or SNOOZE → RELEASE, because the handshake must close.
- `snooze`/`stop` in IDLE or ARMED: no effect.
- A second match while in RINGING is ignored.

## Timing
- Reset (async, `rst_n`=0):
  - state IDLE
  - `enable`=0, `armed`=0, `ringing`=0, `snoozing`=0
  - `snooze_cnt`=0
  - `al`=`tg`=00:00
- Match on a `tick` cycle: `enable` and `ringing` rise at the next edge (1-cycle latency).
- `alert_off`=1 sampled in RINGING: `enable` falls at the next edge.
  - With the companion counter, `alert_off` clears one edge after `enable` falls.
  - RELEASE is therefore held ≥2 cycles before ARMED.
- `enable` never re-asserts while `alert_off`=1. This is the handshake rule.
- `alert_off` is ignored in IDLE, ARMED and SNOOZE.
- A power-up X on `alert_off` is harmless because `enable`=0 holds until the first match.
- Status outputs are registered and decode the state directly.

## Test plan
- Alarm wake-up and handshake:
  - Stimulus: `alarm_set` 07:30, `alarm_on`=1, tick to 07:30:00.
  - Response: `enable`=1 one cycle after the tick.
  - Stimulus: model `alert_off` rising after 6 cycles.
  - Response: `enable`=0 next edge, then `armed`=1 two cycles later; `tg` back to 07:30.
- Snooze with wrap:
  - Stimulus: alarm 23:58, snooze in RINGING.
  - Response: `tg`=00:03, `snoozing`=1, `snooze_cnt`=1.
  - Stimulus: tick to 00:03:00.
  - Response: `ringing`=1 again.
- Snooze limit:
  - Stimulus: `MAX_SNOOZE`=3; snooze three times, re-ringing after each.
  - Response: fourth `snooze` ignored, `enable` stays 1, `snooze_cnt`=3.
- Stop priority:
  - Stimulus: `stop` and `snooze` in the same RINGING cycle.
  - Response: RELEASE, `snooze_cnt`→0, `tg` unchanged by snooze math.
- Disarm mid-ring:
  - Stimulus: `alarm_on`=0 while RINGING.
  - Response: `enable`=0 next edge; IDLE once `alert_off`=0.
  - Stimulus: later match.
  - Response: no `enable`.
- Reset and set blocking:
  - Stimulus: `rst_n` low mid-RINGING.
  - Response: all outputs 0 immediately.
  - Stimulus: `alarm_set` during SNOOZE.
  - Response: `al` unchanged.

Source files
------------

// File: rtl/alarm_trigger.sv
// Alarm initiator: compares the stored alarm against time-of-day and runs the
// enable/alert_off handshake with alert_counter, adding snooze and dismiss.
module alarm_trigger #(
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    input  logic       alarm_on,
    input  logic       alarm_set,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic       snooze,
    input  logic       stop,
    input  logic       alert_off,
    output logic       enable,
    output logic       armed,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_cnt
);

    localparam int unsigned HW = 5;
    localparam int unsigned MW = 6;
    localparam int unsigned CW = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_RINGING = 3'd2,
        S_SNOOZE  = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [HW-1:0] r_al_h;
    logic [MW-1:0] r_al_m;
    logic [HW-1:0] r_tg_h;
    logic [MW-1:0] r_tg_m;
    logic [CW-1:0] r_cnt;
    logic          r_enable;
    logic          r_armed;
    logic          r_ringing;
    logic          r_snoozing;

    logic [HW-1:0] w_al_h_nxt;
    logic [MW-1:0] w_al_m_nxt;
    logic [HW-1:0] w_tg_h_nxt;
    logic [MW-1:0] w_tg_m_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_match;
    logic [MW:0]   w_sum;
    logic          w_wrap;
    logic [MW-1:0] w_snz_m;
    logic [HW-1:0] w_snz_h;
    logic          w_can_snooze;

    assign w_match = tick && (cur_hour == r_tg_h) && (cur_min == r_tg_m) && (cur_sec == 6'd0);

    // Snoozed target: minutes roll into the hour, hour rolls 23 -> 0.
    assign w_sum        = 7'(r_tg_m) + 7'(SNOOZE_MIN);
    assign w_wrap       = (w_sum >= 7'd60);
    assign w_snz_m      = w_wrap ? 6'(w_sum - 7'd60) : 6'(w_sum);
    assign w_snz_h      = !w_wrap ? r_tg_h : ((r_tg_h == 5'd23) ? 5'd0 : r_tg_h + 5'd1);
    assign w_can_snooze = (r_cnt < 3'(MAX_SNOOZE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_al_h     <= '0;
            r_al_m     <= '0;
            r_tg_h     <= '0;
            r_tg_m     <= '0;
            r_cnt      <= '0;
            r_enable   <= 1'b0;
            r_armed    <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_al_h     <= w_al_h_nxt;
            r_al_m     <= w_al_m_nxt;
            r_tg_h     <= w_tg_h_nxt;
            r_tg_m     <= w_tg_m_nxt;
            r_cnt      <= w_cnt_nxt;
            r_enable   <= (w_next == S_RINGING);
            r_armed    <= (w_next == S_ARMED);
            r_ringing  <= (w_next == S_RINGING);
            r_snoozing <= (w_next == S_SNOOZE);
        end
    end

    always_comb begin
        w_next     = r_state;
        w_al_h_nxt = r_al_h;
        w_al_m_nxt = r_al_m;
        w_tg_h_nxt = r_tg_h;
        w_tg_m_nxt = r_tg_m;
        w_cnt_nxt  = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (alarm_on) begin
                    w_next     = S_ARMED;
                    w_tg_h_nxt = r_al_h;
                    w_tg_m_nxt = r_al_m;
                end
                if (alarm_set) begin
                    w_al_h_nxt = set_hour;
                    w_al_m_nxt = set_min;
                    w_tg_h_nxt = set_hour;
                    w_tg_m_nxt = set_min;
                end
            end
            S_ARMED: begin
                if (!alarm_on) begin
                    w_next = S_IDLE;
                end else if (w_match) begin
                    w_next = S_RINGING;
                end
                if (alarm_set) begin
                    w_al_h_nxt = set_hour;
                    w_al_m_nxt = set_min;
                    w_tg_h_nxt = set_hour;
                    w_tg_m_nxt = set_min;
                end
            end
            S_RINGING: begin
                // A snooze at the limit falls through so alert_off still closes.
                if (!alarm_on || stop) begin
                    w_next = S_RELEASE;
                end else if (snooze && w_can_snooze) begin
                    w_next     = S_SNOOZE;
                    w_tg_h_nxt = w_snz_h;
                    w_tg_m_nxt = w_snz_m;
                    w_cnt_nxt  = r_cnt + 3'd1;
                end else if (alert_off) begin
                    w_next = S_RELEASE;
                end
            end
            S_SNOOZE: begin
                if (!alarm_on || stop) begin
                    w_next = S_RELEASE;
                end else if (w_match) begin
                    w_next = S_RINGING;
                end
            end
            S_RELEASE: begin
                if (!alert_off) begin
                    w_next     = alarm_on ? S_ARMED : S_IDLE;
                    w_cnt_nxt  = '0;
                    w_tg_h_nxt = r_al_h;
                    w_tg_m_nxt = r_al_m;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign enable     = r_enable;
    assign armed      = r_armed;
    assign ringing    = r_ringing;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_cnt;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: wake-up handshake, snooze wrap and limit,
// stop priority, disarm, async reset and set blocking.
module tb_alarm_trigger;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       alarm_on;
    logic       alarm_set;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic       snooze;
    logic       stop;
    logic       alert_off;
    logic       enable;
    logic       armed;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    alarm_trigger #(.SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .alarm_on   (alarm_on),
        .alarm_set  (alarm_set),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .snooze     (snooze),
        .stop       (stop),
        .alert_off  (alert_off),
        .enable     (enable),
        .armed      (armed),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Status vector {0, enable, armed, ringing, snoozing, snooze_cnt}.
    function automatic logic [7:0] st(input logic en, input logic arm, input logic rng,
                                      input logic snz, input logic [2:0] cnt);
        return {1'b0, en, arm, rng, snz, cnt};
    endfunction

    function automatic logic [7:0] dut_st();
        return {1'b0, enable, armed, ringing, snoozing, snooze_cnt};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h;
        cur_min  = m;
        cur_sec  = s;
        tick     = 1'b1;
        step(1);
        tick     = 1'b0;
    endtask

    task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
        set_hour  = h;
        set_min   = m;
        alarm_set = 1'b1;
        step(1);
        alarm_set = 1'b0;
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; cur_hour = '0; cur_min = '0; cur_sec = '0;
        alarm_on = 1'b0; alarm_set = 1'b0; set_hour = '0; set_min = '0;
        snooze = 1'b0; stop = 1'b0; alert_off = 1'b0;
        step(2);
        check("reset_state", dut_st(), st(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step(1);
        check("idle_after_reset", dut_st(), st(0, 0, 0, 0, 0));

        // Wake-up and handshake
        load_alarm(5'd7, 6'd30);
        alarm_on = 1'b1;
        step(1);
        check("armed", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd7, 6'd29, 6'd0);
        check("no_ring_early", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd7, 6'd30, 6'd1);
        check("no_ring_sec_nonzero", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd7, 6'd30, 6'd0);
        check("ring_0730", dut_st(), st(1, 0, 1, 0, 0));
        step(5);
        check("ring_holds", dut_st(), st(1, 0, 1, 0, 0));
        alert_off = 1'b1;
        step(1);
        check("release_enable_low", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        alert_off = 1'b0;
        check("release_held", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        check("rearmed", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd7, 6'd30, 6'd0);
        check("tg_restored_0730", dut_st(), st(1, 0, 1, 0, 0));
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        check("stop_release", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        check("stop_rearm", dut_st(), st(0, 1, 0, 0, 0));

        // Snooze with wrap: 23:58 + 5 -> 00:03
        load_alarm(5'd23, 6'd58);
        tick_at(5'd23, 6'd58, 6'd0);
        check("ring_2358", dut_st(), st(1, 0, 1, 0, 0));
        press_snooze();
        check("snooze1", dut_st(), st(0, 0, 0, 1, 1));
        alert_off = 1'b1;
        step(1);
        alert_off = 1'b0;
        check("alert_off_ignored_snooze", dut_st(), st(0, 0, 0, 1, 1));
        tick_at(5'd0, 6'd2, 6'd0);
        check("no_ring_0002", dut_st(), st(0, 0, 0, 1, 1));
        tick_at(5'd23, 6'd58, 6'd0);
        check("no_ring_old_tg", dut_st(), st(0, 0, 0, 1, 1));
        tick_at(5'd0, 6'd3, 6'd0);
        check("rering_0003", dut_st(), st(1, 0, 1, 0, 1));

        // Snooze limit
        press_snooze();
        check("snooze2", dut_st(), st(0, 0, 0, 1, 2));
        tick_at(5'd0, 6'd8, 6'd0);
        check("rering_0008", dut_st(), st(1, 0, 1, 0, 2));
        press_snooze();
        check("snooze3", dut_st(), st(0, 0, 0, 1, 3));
        tick_at(5'd0, 6'd13, 6'd0);
        check("rering_0013", dut_st(), st(1, 0, 1, 0, 3));
        press_snooze();
        check("snooze4_ignored", dut_st(), st(1, 0, 1, 0, 3));
        tick_at(5'd0, 6'd13, 6'd0);
        check("second_match_ignored", dut_st(), st(1, 0, 1, 0, 3));
        alert_off = 1'b1;
        step(1);
        check("limit_release", dut_st(), st(0, 0, 0, 0, 3));
        alert_off = 1'b0;
        step(1);
        check("limit_rearm_cnt0", dut_st(), st(0, 1, 0, 0, 0));

        // Stop beats snooze
        tick_at(5'd23, 6'd58, 6'd0);
        check("ring_again_2358", dut_st(), st(1, 0, 1, 0, 0));
        stop = 1'b1;
        snooze = 1'b1;
        step(1);
        stop = 1'b0;
        snooze = 1'b0;
        check("stop_over_snooze", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        check("stop_snz_rearm", dut_st(), st(0, 1, 0, 0, 0));

        // Disarm mid-ring, handshake still closes
        tick_at(5'd23, 6'd58, 6'd0);
        check("ring_for_disarm", dut_st(), st(1, 0, 1, 0, 0));
        alarm_on = 1'b0;
        alert_off = 1'b1;
        step(1);
        check("disarm_enable_low", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        alert_off = 1'b0;
        step(1);
        tick_at(5'd23, 6'd58, 6'd0);
        check("idle_no_enable", dut_st(), st(0, 0, 0, 0, 0));

        // Set ignored during SNOOZE
        alarm_on = 1'b1;
        step(1);
        check("rearm_from_idle", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd23, 6'd58, 6'd0);
        press_snooze();
        check("snooze_for_set", dut_st(), st(0, 0, 0, 1, 1));
        load_alarm(5'd6, 6'd0);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(1);
        check("armed_after_set_block", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd6, 6'd0, 6'd0);
        check("set_blocked_no_0600", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd23, 6'd58, 6'd0);
        check("al_kept_2358", dut_st(), st(1, 0, 1, 0, 0));

        // Async reset mid-ring clears outputs without a clock edge
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_st(), st(0, 0, 0, 0, 0));
        step(1);
        rst_n = 1'b1;
        step(1);
        check("armed_after_reset", dut_st(), st(0, 1, 0, 0, 0));
        tick_at(5'd0, 6'd0, 6'd0);
        check("reset_al_0000", dut_st(), st(1, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
